// File: rtl/fma_result_stage_if.sv
// fma_result_stage_if: handshake/data bundle around the FMA result stage.
//   Upstream (rounder) side : In_valid_i, In_ready_o, Sign/Exp/Mant_result_i,
//                             Invalid_i, Overflow_i, Underflow_i, Inexact_i
//   Downstream side         : Out_valid_o, Out_ready_i, Out_data_o, Out_fflags_o
//   Sticky flag accumulator : Fflags_clr_i, Fflags_acc_o
// The slave modport is the stage's view; master is the environment driving it.
interface fma_result_stage_if #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23,
  parameter int PARM_XLEN = 32
);
  logic                 In_valid_i;
  logic                 In_ready_o;
  logic                 Sign_result_i;
  logic [PARM_EXP-1:0]  Exp_result_i;
  logic [PARM_MANT-1:0] Mant_result_i;
  logic                 Invalid_i;
  logic                 Overflow_i;
  logic                 Underflow_i;
  logic                 Inexact_i;
  logic                 Out_valid_o;
  logic                 Out_ready_i;
  logic [PARM_XLEN-1:0] Out_data_o;
  logic [4:0]           Out_fflags_o;
  logic                 Fflags_clr_i;
  logic [4:0]           Fflags_acc_o;

  modport slave (
    input  In_valid_i, Sign_result_i, Exp_result_i, Mant_result_i,
           Invalid_i, Overflow_i, Underflow_i, Inexact_i,
           Out_ready_i, Fflags_clr_i,
    output In_ready_o, Out_valid_o, Out_data_o, Out_fflags_o, Fflags_acc_o
  );

  modport master (
    output In_valid_i, Sign_result_i, Exp_result_i, Mant_result_i,
           Invalid_i, Overflow_i, Underflow_i, Inexact_i,
           Out_ready_i, Fflags_clr_i,
    input  In_ready_o, Out_valid_o, Out_data_o, Out_fflags_o, Fflags_acc_o
  );
endinterface

// File: rtl/fma_result_stage.sv
// fma_result_stage: final FMA stage. Packs the rounded sign/exponent/mantissa
// into an IEEE word (canonical NaN on invalid), pairs it with the per-op
// exception flags {NV,DZ,OF,UF,NX}, and buffers both in a 2-entry FIFO.
// Optionally ORs popped flags into a sticky accumulator.
// Ports:
//   Clk_i  - clock
//   Rst_i  - synchronous, active-high reset (clears occupancy, pointers, acc)
//   bus    - fma_result_stage_if.slave (upstream, downstream, flag accumulator)
// Build option:
//   FMA_FFLAGS_ACCUM_EN - when defined, Fflags_acc_o is a sticky register;
//                         otherwise it is tied to zero and Fflags_clr_i unused.
module fma_result_stage #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23,
  parameter int PARM_XLEN = 32
) (
  input logic                  Clk_i,
  input logic                  Rst_i,
  fma_result_stage_if.slave    bus
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_e;

  occ_e                 state, state_nxt;
  logic                 wr_ptr, rd_ptr;
  logic [PARM_XLEN-1:0] data_q  [2];
  logic [4:0]           flags_q [2];
  logic                 push, pop;
  logic [PARM_XLEN-1:0] in_word;
  logic [4:0]           in_flags;

  // Handshakes come off the registered occupancy only, so a pop while FULL
  // does not open the input in the same cycle.
  assign push = bus.In_valid_i  && bus.In_ready_o;
  assign pop  = bus.Out_valid_o && bus.Out_ready_i;

  // Invalid forces the canonical quiet NaN regardless of the rounded fields.
  assign in_word  = bus.Invalid_i
                  ? {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}}
                  : {bus.Sign_result_i, bus.Exp_result_i, bus.Mant_result_i};
  assign in_flags = {bus.Invalid_i, 1'b0, bus.Overflow_i, bus.Underflow_i, bus.Inexact_i};

  // Occupancy state register
  always_ff @(posedge Clk_i) begin
    if (Rst_i) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Occupancy next state
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Outputs; data and flags read as zero while empty
  always_comb begin
    bus.In_ready_o   = (state != FULL);
    bus.Out_valid_o  = (state != EMPTY);
    bus.Out_data_o   = '0;
    bus.Out_fflags_o = '0;
    if (state != EMPTY) begin
      bus.Out_data_o   = data_q[rd_ptr];
      bus.Out_fflags_o = flags_q[rd_ptr];
    end
  end

  // 1-bit pointers wrap naturally 1 -> 0
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // Storage needs no reset: contents are masked by the occupancy state.
  // Only the slot at wr_ptr is written, so the other entry is never disturbed.
  always_ff @(posedge Clk_i) begin
    if (push) begin
      data_q[wr_ptr]  <= in_word;
      flags_q[wr_ptr] <= in_flags;
    end
  end

`ifdef FMA_FFLAGS_ACCUM_EN
  logic [4:0] acc_q;

  // Clear wipes history but a same-cycle pop still lands its flags.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) acc_q <= '0;
    else       acc_q <= (bus.Fflags_clr_i ? 5'b0 : acc_q) | (pop ? bus.Out_fflags_o : 5'b0);
  end

  assign bus.Fflags_acc_o = acc_q;
`else
  assign bus.Fflags_acc_o = 5'b0;
`endif

endmodule
